// File: rtl/cache_controller.sv
// Single-level cache controller: compare, optional victim writeback, line allocate.
// All outputs are combinational from the registered state, latched request and live inputs.
module cache_controller #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  output logic [1:0] state_test,
  output logic [1:0] state_next_test,
  input  logic       req_cpu_i,
  input  logic       adr_cpu_i,
  input  logic       dat_cpu_i,
  input  logic       we_cpu_i,
  input  logic       dat_mem_i,
  input  logic       ack_mem_i,
  input  logic       cc_hit_i,
  input  logic       cc_dat_i,
  input  logic       cc_valid_i,
  input  logic       adr_mshr_load_i,
  input  logic       dat_mshr_load_i,
  input  logic       adr_mshr_deload_i,
  input  logic       dat_mshr_deload_i,
  input  logic       lru,
  input  logic       free,
  output logic       dat_cpu_o,
  output logic       ack_cpu_o,
  output logic       err_cpu_o,
  output logic       cyc_m2s,
  output logic       we_m2s,
  output logic       adr_m2s,
  output logic       dat_m2s,
  output logic       cc_we_o,
  output logic       cc_adr_o,
  output logic       cc_dat_o,
  output logic       adr_mshr_load_o,
  output logic       dat_mshr_load_o,
  output logic       adr_mshr_deload_o,
  output logic       dat_mshr_deload_o
);

  typedef enum logic [1:0] {
    StIdle      = 2'b00,
    StCompare   = 2'b01,
    StWriteback = 2'b10,
    StAllocate  = 2'b11
  } state_e;

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  state_e          state_q, state_d;
  logic            adr_q, adr_d;
  logic            dat_q, dat_d;
  logic            we_q, we_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            hit;
  logic            timeout;

  assign hit     = cc_hit_i & cc_valid_i;
  // Last permitted wait cycle: a missing ack here aborts the request.
  assign timeout = (cnt_q == CntW'(TIMEOUT - 1));

  assign state_test      = state_q;
  assign state_next_test = state_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      adr_q   <= 1'b0;
      dat_q   <= 1'b0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    adr_d             = adr_q;
    dat_d             = dat_q;
    we_d              = we_q;
    cnt_d             = cnt_q;
    dat_cpu_o         = 1'b0;
    ack_cpu_o         = 1'b0;
    err_cpu_o         = 1'b0;
    cyc_m2s           = 1'b0;
    we_m2s            = 1'b0;
    adr_m2s           = 1'b0;
    dat_m2s           = 1'b0;
    cc_we_o           = 1'b0;
    cc_adr_o          = 1'b0;
    cc_dat_o          = 1'b0;
    adr_mshr_load_o   = 1'b0;
    dat_mshr_load_o   = 1'b0;
    adr_mshr_deload_o = 1'b0;
    dat_mshr_deload_o = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_cpu_i) begin
          adr_d   = adr_cpu_i;
          dat_d   = dat_cpu_i;
          we_d    = we_cpu_i;
          state_d = StCompare;
        end
      end

      StCompare: begin
        cc_adr_o = adr_q;
        if (hit) begin
          ack_cpu_o = 1'b1;
          if (we_q) begin
            cc_we_o  = 1'b1;
            cc_dat_o = dat_q;
          end else begin
            dat_cpu_o = cc_dat_i;
          end
          state_d = StIdle;
        end else begin
          adr_mshr_load_o = adr_q;
          dat_mshr_load_o = dat_q;
          cnt_d           = '0;
          if (free) begin
            state_d = StAllocate;
          end else begin
            adr_mshr_deload_o = lru;
            dat_mshr_deload_o = cc_dat_i;
            state_d           = StWriteback;
          end
        end
      end

      StWriteback: begin
        if (ack_mem_i || !timeout) begin
          cyc_m2s = 1'b1;
          we_m2s  = 1'b1;
          adr_m2s = adr_mshr_deload_i;
          dat_m2s = dat_mshr_deload_i;
        end
        if (ack_mem_i) begin
          cnt_d   = '0;
          state_d = StAllocate;
        end else if (timeout) begin
          err_cpu_o = 1'b1;
          cnt_d     = '0;
          state_d   = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StAllocate: begin
        if (ack_mem_i || !timeout) begin
          cyc_m2s = 1'b1;
          adr_m2s = adr_mshr_load_i;
        end
        if (ack_mem_i) begin
          cc_we_o   = 1'b1;
          cc_adr_o  = adr_q;
          cc_dat_o  = we_q ? dat_mshr_load_i : dat_mem_i;
          ack_cpu_o = 1'b1;
          dat_cpu_o = we_q ? 1'b0 : dat_mem_i;
          cnt_d     = '0;
          state_d   = StIdle;
        end else if (timeout) begin
          err_cpu_o = 1'b1;
          cnt_d     = '0;
          state_d   = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: directed scenarios with literal expectations, then random
// traffic checked every cycle against a request-level reference model.
module tb_cache_controller;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] state_test, state_next_test;
  logic req_cpu_i, adr_cpu_i, dat_cpu_i, we_cpu_i, dat_mem_i, ack_mem_i;
  logic cc_hit_i, cc_dat_i, cc_valid_i;
  logic adr_mshr_load_i, dat_mshr_load_i, adr_mshr_deload_i, dat_mshr_deload_i, lru, free;
  logic dat_cpu_o, ack_cpu_o, err_cpu_o, cyc_m2s, we_m2s, adr_m2s, dat_m2s;
  logic cc_we_o, cc_adr_o, cc_dat_o;
  logic adr_mshr_load_o, dat_mshr_load_o, adr_mshr_deload_o, dat_mshr_deload_o;

  int n_tests = 0;
  int n_fail  = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  cache_controller #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .state_test(state_test), .state_next_test(state_next_test),
    .req_cpu_i(req_cpu_i), .adr_cpu_i(adr_cpu_i), .dat_cpu_i(dat_cpu_i), .we_cpu_i(we_cpu_i),
    .dat_mem_i(dat_mem_i), .ack_mem_i(ack_mem_i), .cc_hit_i(cc_hit_i), .cc_dat_i(cc_dat_i),
    .cc_valid_i(cc_valid_i), .adr_mshr_load_i(adr_mshr_load_i),
    .dat_mshr_load_i(dat_mshr_load_i), .adr_mshr_deload_i(adr_mshr_deload_i),
    .dat_mshr_deload_i(dat_mshr_deload_i), .lru(lru), .free(free),
    .dat_cpu_o(dat_cpu_o), .ack_cpu_o(ack_cpu_o), .err_cpu_o(err_cpu_o), .cyc_m2s(cyc_m2s),
    .we_m2s(we_m2s), .adr_m2s(adr_m2s), .dat_m2s(dat_m2s), .cc_we_o(cc_we_o),
    .cc_adr_o(cc_adr_o), .cc_dat_o(cc_dat_o), .adr_mshr_load_o(adr_mshr_load_o),
    .dat_mshr_load_o(dat_mshr_load_o), .adr_mshr_deload_o(adr_mshr_deload_o),
    .dat_mshr_deload_o(dat_mshr_deload_o)
  );

  logic [17:0] outv;
  assign outv = {dat_cpu_o, ack_cpu_o, err_cpu_o, cyc_m2s, we_m2s, adr_m2s, dat_m2s,
                 cc_we_o, cc_adr_o, cc_dat_o, adr_mshr_load_o, dat_mshr_load_o,
                 adr_mshr_deload_o, dat_mshr_deload_o, state_test, state_next_test};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: where the pending request is, and how long it has waited on memory.
  localparam int PhIdle = 0, PhCompare = 1, PhWriteback = 2, PhAllocate = 3;
  int   m_ph = PhIdle, n_ph;
  int   m_waited = 0, n_waited;
  logic m_adr = 1'b0, m_dat = 1'b0, m_we = 1'b0;
  logic n_adr, n_dat, n_we;
  logic e_dc, e_ack, e_err, e_cyc, e_wm, e_am, e_dm, e_cwe, e_cad, e_cdt;
  logic e_al, e_dl, e_ad, e_dd;
  logic [17:0] expv;

  always @(negedge clk) begin
    if (started) begin
      {e_dc, e_ack, e_err, e_cyc, e_wm, e_am, e_dm, e_cwe, e_cad, e_cdt} = '0;
      {e_al, e_dl, e_ad, e_dd} = '0;
      n_ph = m_ph; n_waited = m_waited + 1;
      n_adr = m_adr; n_dat = m_dat; n_we = m_we;
      if (m_ph == PhIdle) begin
        if (req_cpu_i === 1'b1) begin
          n_adr = adr_cpu_i; n_dat = dat_cpu_i; n_we = we_cpu_i; n_ph = PhCompare;
        end
      end else if (m_ph == PhCompare) begin
        e_cad = m_adr;
        if (cc_hit_i === 1'b1 && cc_valid_i === 1'b1) begin
          e_ack = 1'b1;
          if (m_we) begin e_cwe = 1'b1; e_cdt = m_dat; end
          else e_dc = cc_dat_i;
          n_ph = PhIdle;
        end else begin
          e_al = m_adr; e_dl = m_dat; n_waited = 0;
          if (free) n_ph = PhAllocate;
          else begin e_ad = lru; e_dd = cc_dat_i; n_ph = PhWriteback; end
        end
      end else if (ack_mem_i) begin
        e_cyc = 1'b1; n_waited = 0;
        if (m_ph == PhWriteback) begin
          e_wm = 1'b1; e_am = adr_mshr_deload_i; e_dm = dat_mshr_deload_i; n_ph = PhAllocate;
        end else begin
          e_am = adr_mshr_load_i; e_cwe = 1'b1; e_cad = m_adr; e_ack = 1'b1;
          e_cdt = m_we ? dat_mshr_load_i : dat_mem_i;
          e_dc  = m_we ? 1'b0 : dat_mem_i;
          n_ph  = PhIdle;
        end
      end else if (m_waited + 1 >= TO) begin
        e_err = 1'b1; n_ph = PhIdle; n_waited = 0;
      end else begin
        e_cyc = 1'b1;
        if (m_ph == PhWriteback) begin
          e_wm = 1'b1; e_am = adr_mshr_deload_i; e_dm = dat_mshr_deload_i;
        end else e_am = adr_mshr_load_i;
      end
      expv = {e_dc, e_ack, e_err, e_cyc, e_wm, e_am, e_dm, e_cwe, e_cad, e_cdt,
              e_al, e_dl, e_ad, e_dd, 2'(m_ph), 2'(n_ph)};
      check("model_outputs", 32'(outv), 32'(expv));
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      m_ph <= PhIdle; m_waited <= 0; m_adr <= 1'b0; m_dat <= 1'b0; m_we <= 1'b0;
    end else if (started) begin
      m_ph <= n_ph; m_waited <= n_waited; m_adr <= n_adr; m_dat <= n_dat; m_we <= n_we;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    {req_cpu_i, adr_cpu_i, dat_cpu_i, we_cpu_i, dat_mem_i, ack_mem_i} = '0;
    {cc_hit_i, cc_dat_i, cc_valid_i, lru, free} = '0;
    {adr_mshr_load_i, dat_mshr_load_i, adr_mshr_deload_i, dat_mshr_deload_i} = '0;
  endtask

  task automatic request(input logic a, input logic d, input logic w);
    clr(); req_cpu_i = 1'b1; adr_cpu_i = a; dat_cpu_i = d; we_cpu_i = w;
    step(); clr();
  endtask

  initial begin
    int  k;
    bit  found;
    clr(); rst = 1'b1;
    repeat (5) step();
    started = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_idle_outputs", 32'(outv), 32'h0);

    // Read hit
    request(1'b0, 1'b0, 1'b0);
    cc_hit_i = 1'b1; cc_valid_i = 1'b1; cc_dat_i = 1'b1;
    @(negedge clk);
    check("rd_hit_state", 32'(state_test), 32'd1);
    check("rd_hit_ack_dat", 32'({ack_cpu_o, dat_cpu_o, state_next_test}), 32'b1100);
    step(); clr();
    @(negedge clk);
    check("rd_hit_back_idle", 32'({state_test, ack_cpu_o}), 32'b000);

    // Write hit
    request(1'b0, 1'b1, 1'b1);
    cc_hit_i = 1'b1; cc_valid_i = 1'b1;
    @(negedge clk);
    check("wr_hit", 32'({cc_we_o, cc_dat_o, cc_adr_o, ack_cpu_o}), 32'b1101);
    step(); clr();

    // Read miss, free line
    request(1'b1, 1'b0, 1'b0);
    free = 1'b1;
    @(negedge clk);
    check("rd_miss_load", 32'({adr_mshr_load_o, state_next_test}), 32'b111);
    step(); clr();
    ack_mem_i = 1'b1; adr_mshr_load_i = 1'b1;
    @(negedge clk);
    check("rd_miss_alloc",
          32'({cyc_m2s, we_m2s, adr_m2s, cc_we_o, cc_adr_o, ack_cpu_o, dat_cpu_o}),
          32'b1011110);
    step(); clr();

    // Write miss, free line
    request(1'b1, 1'b0, 1'b1);
    free = 1'b1;
    step(); clr();
    ack_mem_i = 1'b1; dat_mshr_load_i = 1'b1;
    @(negedge clk);
    check("wr_miss_alloc", 32'({cc_we_o, cc_dat_o, ack_cpu_o, dat_cpu_o}), 32'b1110);
    step(); clr();

    // Miss with eviction
    request(1'b1, 1'b0, 1'b0);
    lru = 1'b1; cc_dat_i = 1'b1;
    @(negedge clk);
    check("evict_deload", 32'({adr_mshr_deload_o, dat_mshr_deload_o, state_next_test}),
          32'b1110);
    step(); clr();
    ack_mem_i = 1'b1; adr_mshr_deload_i = 1'b1; dat_mshr_deload_i = 1'b1;
    @(negedge clk);
    check("evict_wb", 32'({state_test, cyc_m2s, we_m2s, adr_m2s, dat_m2s}), 32'b101111);
    step(); clr();
    ack_mem_i = 1'b1; dat_mem_i = 1'b1; adr_mshr_load_i = 1'b1;
    @(negedge clk);
    check("evict_alloc", 32'({state_test, ack_cpu_o, dat_cpu_o, cc_dat_o}), 32'b11111);
    step(); clr();

    // Timeout in ALLOCATE: error on the TO-th waiting cycle
    request(1'b0, 1'b0, 1'b0);
    free = 1'b1;
    step(); clr();
    k = 0; found = 1'b0;
    while (k < 40 && !found) begin
      @(negedge clk);
      k++;
      if (err_cpu_o) found = 1'b1;
      else step();
    end
    check("timeout_cycles", 32'(found ? k : 0), 32'(TO));
    check("timeout_pulse", 32'({ack_cpu_o, cyc_m2s, cc_we_o, state_next_test}), 32'b00000);
    step();
    @(negedge clk);
    check("timeout_single", 32'({err_cpu_o, state_test}), 32'b000);

    // Reset while in ALLOCATE
    request(1'b1, 1'b1, 1'b1);
    free = 1'b1;
    step(); clr();
    step(); step();
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_state", 32'(state_test), 32'd3);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_idle", 32'({state_test, ack_cpu_o, err_cpu_o}), 32'b0000);

    // Random traffic
    repeat (4000) begin
      step();
      rst               = ($urandom_range(0, 99) == 0);
      req_cpu_i         = $urandom_range(0, 1) == 1;
      adr_cpu_i         = $urandom_range(0, 1) == 1;
      dat_cpu_i         = $urandom_range(0, 1) == 1;
      we_cpu_i          = $urandom_range(0, 1) == 1;
      dat_mem_i         = $urandom_range(0, 1) == 1;
      ack_mem_i         = ($urandom_range(0, 5) == 0);
      cc_hit_i          = $urandom_range(0, 1) == 1;
      cc_valid_i        = $urandom_range(0, 3) != 0;
      cc_dat_i          = $urandom_range(0, 1) == 1;
      adr_mshr_load_i   = $urandom_range(0, 1) == 1;
      dat_mshr_load_i   = $urandom_range(0, 1) == 1;
      adr_mshr_deload_i = $urandom_range(0, 1) == 1;
      dat_mshr_deload_i = $urandom_range(0, 1) == 1;
      lru               = $urandom_range(0, 1) == 1;
      free              = $urandom_range(0, 1) == 1;
    end
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 Parameter: TIMEOUT, 16, max cycles waiting for ack_mem_i in WRITEBACK/ALLOCATE before error abort.
REQ-002 Clock/reset: one clock; reset is synchronous and active-high; ports named clk and rst.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 state_test  out  2  current FSM state.
REQ-006 state_next_test  out  2  combinational next FSM state.
REQ-007 req_cpu_i, adr_cpu_i, dat_cpu_i, we_cpu_i  in  1 each  CPU request strobe, address, write data, write enable (1=write).
REQ-008 dat_mem_i, ack_mem_i  in  1 each  memory read data, memory acknowledge.
REQ-009 cc_hit_i, cc_dat_i, cc_valid_i  in  1 each  cache tag hit, cache read data, line valid.
REQ-010 adr_mshr_load_i, dat_mshr_load_i  in  1 each  MSHR readback of pending-miss address/data.
REQ-011 adr_mshr_deload_i, dat_mshr_deload_i  in  1 each  MSHR readback of victim address/data.
REQ-012 lru, free  in  1 each  LRU victim address; 1 = free line available, no eviction.
REQ-013 dat_cpu_o, ack_cpu_o, err_cpu_o  out  1 each  CPU read data, done pulse, error pulse.
REQ-014 cyc_m2s, we_m2s, adr_m2s, dat_m2s  out  1 each  memory cycle, write enable, address, write data.
REQ-015 cc_we_o, cc_adr_o, cc_dat_o  out  1 each  cache array write enable, address, write data.
REQ-016 adr_mshr_load_o, dat_mshr_load_o  out  1 each  pending-miss address/data into MSHR.
REQ-017 adr_mshr_deload_o, dat_mshr_deload_o  out  1 each  victim address/data into MSHR.

Function
REQ-018 States: IDLE=2'b00, COMPARE=2'b01, WRITEBACK=2'b10, ALLOCATE=2'b11; state registered, all outputs combinational from state, latched request and inputs.
REQ-019 IDLE: req_cpu_i=1 -> latch adr/dat/we into request regs, next COMPARE; else stay. req_cpu_i is only sampled in IDLE.
REQ-020 COMPARE: cc_adr_o=latched adr; hit = cc_hit_i & cc_valid_i.
REQ-021 COMPARE read hit: dat_cpu_o=cc_dat_i, ack_cpu_o=1 that cycle, next IDLE.
REQ-022 COMPARE write hit: cc_we_o=1, cc_dat_o=latched dat, ack_cpu_o=1, next IDLE.
REQ-023 COMPARE miss: adr_mshr_load_o=latched adr, dat_mshr_load_o=latched dat; free=1 -> ALLOCATE; free=0 -> WRITEBACK with adr_mshr_deload_o=lru, dat_mshr_deload_o=cc_dat_i.
REQ-024 WRITEBACK: cyc_m2s=1, we_m2s=1, adr_m2s=adr_mshr_deload_i, dat_m2s=dat_mshr_deload_i; ack_mem_i=1 -> ALLOCATE.
REQ-025 ALLOCATE: cyc_m2s=1, we_m2s=0, adr_m2s=adr_mshr_load_i; on ack_mem_i=1: cc_we_o=1, cc_adr_o=latched adr, cc_dat_o = we ? dat_mshr_load_i : dat_mem_i, ack_cpu_o=1, dat_cpu_o = we ? 0 : dat_mem_i, next IDLE.
REQ-026 Wait counter cleared on entry to WRITEBACK/ALLOCATE; reaching TIMEOUT cycles without ack_mem_i -> err_cpu_o=1 one cycle, cyc_m2s=0, next IDLE, no cache write.
REQ-027 ack_cpu_o and err_cpu_o never both 1; each is a single-cycle pulse per request.
REQ-028 Outputs not explicitly driven in a state are 0; X/undriven cc_hit_i/cc_valid_i treated as miss.

Reset
REQ-029 rst=1 at a clock edge -> state IDLE, request regs and counter 0, aborting any transaction mid-flight; while in IDLE with no request all outputs are 0, state_test=2'b00.

Verification
REQ-030 Read hit: rst 5 cycles, req=1 adr=0 we=0, hit=1 valid=1 cc_dat=1 -> COMPARE next cycle, dat_cpu_o=1, ack_cpu_o=1, back to IDLE.
REQ-031 Write hit: req=1 adr=0 dat=1 we=1, hit=valid=1 -> cc_we_o=1, cc_dat_o=1, cc_adr_o=0, ack pulse, IDLE.
REQ-032 Read miss free=1: req=1 adr=1 we=0, hit=0, ack_mem=1 dat_mem=0 -> COMPARE->ALLOCATE, cyc_m2s=1 we_m2s=0, cc_we_o=1, ack pulse, dat_cpu_o=0.
REQ-033 Write miss free=1: adr=1 dat=0 we=1 -> ALLOCATE, cc_dat_o=dat_mshr_load_i, ack pulse, IDLE.
REQ-034 Read/write miss free=0 lru=1, MSHR inputs=1, dat_mem=1: adr_mshr_deload_o=1, WRITEBACK with we_m2s=1, then ALLOCATE, ack pulse, IDLE.
REQ-035 Timeout/reset: miss with ack_mem=0 -> err_cpu_o after TIMEOUT=16 cycles; rst asserted mid-ALLOCATE -> IDLE next edge, no ack.
